// File: rtl/coder_pkg.sv
// Shared definitions for the turbo-encoder output collector: stream ids,
// writer/reader state encodings and the default block depth.
package coder_pkg;

    localparam int DEFAULT_DEPTH = 1024;

    localparam logic [1:0] STR_XK = 2'd0;
    localparam logic [1:0] STR_ZK = 2'd1;
    localparam logic [1:0] STR_ZP = 2'd2;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_DROP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_XK,
        R_ZK,
        R_ZP
    } rd_state_t;

    // Reader state that keeps issuing addresses inside a given section.
    function automatic rd_state_t sec_state(input logic [1:0] sec);
        case (sec)
            STR_ZK:  return R_ZK;
            STR_ZP:  return R_ZP;
            default: return R_XK;
        endcase
    endfunction

endpackage

// File: rtl/enc_out_collector_if.sv
// Encoder-side beat inputs and the rate-matching byte stream, bundled for the collector.
interface enc_out_collector_if;

    logic [7:0] xk_in;
    logic [7:0] zk_in;
    logic [7:0] zk_prime_in;
    logic       in_valid;

    logic [7:0] out_data;
    logic [1:0] out_stream;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  xk_in, zk_in, zk_prime_in, in_valid, out_ready,
        output out_data, out_stream, out_last, out_valid
    );

    modport master (
        output xk_in, zk_in, zk_prime_in, in_valid, out_ready,
        input  out_data, out_stream, out_last, out_valid
    );

endinterface

// File: rtl/enc_out_bank_ram.sv
// One ping-pong bank: a beat writes all three sections at one index; the read
// port returns one byte addressed by {section, index} with a registered output.
module enc_out_bank_ram
    import coder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [23:0]   wdata,
    input  logic          re,
    input  logic [AW+1:0] raddr,
    output logic [7:0]    rdata
);

    logic [2:0][7:0] q_all;
    logic [1:0]      sec_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sec
            logic [7:0] mem [DEPTH];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= wdata[gi*8 +: 8];
                end
                if (re) begin
                    q_reg <= mem[raddr[AW-1:0]];
                end
            end

            assign q_all[gi] = q_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (re) begin
            sec_reg <= raddr[AW+1:AW];
        end
    end

    always_comb begin
        rdata = q_all[0];
        if (sec_reg == STR_ZK) begin
            rdata = q_all[1];
        end else if (sec_reg == STR_ZP) begin
            rdata = q_all[2];
        end
    end

endmodule

// File: rtl/enc_out_collector.sv
// Captures encoder beats into two ping-pong banks and replays each committed
// block as xk bytes, then zk, then zk', through a 1-cycle RAM read plus 2-entry skid.
module enc_out_collector
    import coder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    enc_out_collector_if.slave bus,
    output logic               ovf_drop,
    output logic               ovf_len
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    // Writer
    wr_state_t     wr_state_reg, wr_state_next;
    logic          wbank_reg, wbank_next;
    logic [AW:0]   wcnt_reg, wcnt_next;
    logic          wr_en, commit, set_drop, set_len;
    logic [AW-1:0] waddr;

    // Bank bookkeeping
    logic [1:0]    full_reg, pend_reg;
    logic [1:0]    free, full_after, rel_mask, start_mask, commit_mask;
    logic [AW:0]   len_reg [2];
    logic          oldest_reg, oldest_next;
    logic          ovf_drop_reg, ovf_len_reg;

    // Reader
    rd_state_t     rd_state_reg, rd_state_next;
    logic          rbank_reg, rbank_next;
    logic [AW-1:0] ridx_reg, ridx_next;
    logic          cur_bank;
    logic [1:0]    cur_sec;
    logic [AW-1:0] cur_idx;
    logic [AW:0]   cur_len;
    logic          active, can_issue, issue, sec_last;
    logic [AW+1:0] raddr;
    logic [1:0][7:0] rdata;

    // Read pipeline stage and skid buffer
    logic          rd_vld_reg, rd_bank_reg, rd_last_reg;
    logic [1:0]    rd_stream_reg;
    logic [7:0]    fifo_data_reg [2];
    logic [1:0]    fifo_stream_reg [2];
    logic [1:0]    fifo_last_reg, fifo_bank_reg;
    logic          head_reg;
    logic [1:0]    count_reg;
    logic [2:0]    occ;
    logic          consume, push, pop, rel;

    logic [7:0]    out_data;
    logic [1:0]    out_stream;
    logic          out_last, out_valid, out_bank;

    // ---------------- output stage ----------------
    always_comb begin
        out_valid  = (count_reg != 2'd0) | rd_vld_reg;
        out_data   = '0;
        out_stream = STR_XK;
        out_last   = 1'b0;
        out_bank   = 1'b0;
        if (count_reg != 2'd0) begin
            out_data   = fifo_data_reg[head_reg];
            out_stream = fifo_stream_reg[head_reg];
            out_last   = fifo_last_reg[head_reg];
            out_bank   = fifo_bank_reg[head_reg];
        end else if (rd_vld_reg) begin
            out_data   = rdata[rd_bank_reg];
            out_stream = rd_stream_reg;
            out_last   = rd_last_reg;
            out_bank   = rd_bank_reg;
        end
    end

    assign bus.out_data   = out_data;
    assign bus.out_stream = out_stream;
    assign bus.out_last   = out_last;
    assign bus.out_valid  = out_valid;

    assign consume  = out_valid & bus.out_ready;
    assign pop      = (count_reg != 2'd0) & consume;
    // RAM data goes to the skid unless it leaves straight from the RAM register.
    assign push     = rd_vld_reg & ~((count_reg == 2'd0) & consume);
    assign rel      = consume & out_last;
    assign rel_mask = {out_bank, ~out_bank} & {2{rel}};

    // Issue only if the byte in flight can still land in the skid next cycle.
    assign occ       = {1'b0, count_reg} + {2'b00, rd_vld_reg} - {2'b00, consume};
    assign can_issue = (occ <= 3'd1);

    // ---------------- writer ----------------
    // A bank released this cycle is already free to a run that starts now.
    assign free        = ~full_reg | rel_mask;
    assign commit_mask = {wbank_reg, ~wbank_reg} & {2{commit}};
    assign full_after  = full_reg & ~rel_mask;

    always_comb begin
        wr_state_next = wr_state_reg;
        wbank_next    = wbank_reg;
        wcnt_next     = wcnt_reg;
        wr_en         = 1'b0;
        waddr         = '0;
        commit        = 1'b0;
        set_drop      = 1'b0;
        set_len       = 1'b0;
        case (wr_state_reg)
            W_IDLE: begin
                if (bus.in_valid) begin
                    if (free != 2'b00) begin
                        wr_state_next = W_FILL;
                        wbank_next    = ~free[0];
                        wr_en         = 1'b1;
                        wcnt_next     = (AW+1)'(1);
                    end else begin
                        wr_state_next = W_DROP;
                        set_drop      = 1'b1;
                    end
                end
            end
            W_FILL: begin
                if (bus.in_valid) begin
                    if (wcnt_reg < DEPTH_L) begin
                        wr_en     = 1'b1;
                        waddr     = wcnt_reg[AW-1:0];
                        wcnt_next = wcnt_reg + (AW+1)'(1);
                    end else begin
                        set_len = 1'b1;
                    end
                end else begin
                    commit        = 1'b1;
                    wr_state_next = W_IDLE;
                end
            end
            W_DROP: begin
                if (!bus.in_valid) begin
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        oldest_next = oldest_reg ^ rel;
        if (commit && !full_after[~wbank_reg]) begin
            oldest_next = wbank_reg;
        end
    end

    // ---------------- reader ----------------
    always_comb begin
        cur_bank = rbank_reg;
        cur_sec  = STR_XK;
        cur_idx  = ridx_reg;
        active   = 1'b1;
        case (rd_state_reg)
            R_IDLE: begin
                cur_bank = pend_reg[oldest_reg] ? oldest_reg : ~oldest_reg;
                cur_idx  = '0;
                active   = |pend_reg;
            end
            R_ZK:    cur_sec = STR_ZK;
            R_ZP:    cur_sec = STR_ZP;
            default: cur_sec = STR_XK;
        endcase
        cur_len    = len_reg[cur_bank];
        sec_last   = (({1'b0, cur_idx} + (AW+1)'(1)) == cur_len);
        issue      = active & can_issue;
        raddr      = {cur_sec, cur_idx};
        start_mask = {cur_bank, ~cur_bank} & {2{issue & (rd_state_reg == R_IDLE)}};

        rd_state_next = rd_state_reg;
        rbank_next    = rbank_reg;
        ridx_next     = ridx_reg;
        if (issue) begin
            rbank_next = cur_bank;
            if (!sec_last) begin
                rd_state_next = sec_state(cur_sec);
                ridx_next     = cur_idx + AW'(1);
            end else begin
                ridx_next = '0;
                case (cur_sec)
                    STR_XK:  rd_state_next = R_ZK;
                    STR_ZK:  rd_state_next = R_ZP;
                    default: rd_state_next = R_IDLE;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            enc_out_bank_ram #(
                .DEPTH(DEPTH),
                .AW   (AW)
            ) u_ram (
                .clk  (clk),
                .we   (wr_en && (wbank_next == 1'(gi))),
                .waddr(waddr),
                .wdata({bus.zk_prime_in, bus.zk_in, bus.xk_in}),
                .re   (issue && (cur_bank == 1'(gi))),
                .raddr(raddr),
                .rdata(rdata[gi])
            );
        end
    endgenerate

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_reg <= W_IDLE;
            wbank_reg    <= 1'b0;
            wcnt_reg     <= '0;
            full_reg     <= '0;
            pend_reg     <= '0;
            len_reg[0]   <= '0;
            len_reg[1]   <= '0;
            oldest_reg   <= 1'b0;
            ovf_drop_reg <= 1'b0;
            ovf_len_reg  <= 1'b0;
            rd_state_reg <= R_IDLE;
            rbank_reg    <= 1'b0;
            ridx_reg     <= '0;
            rd_vld_reg   <= 1'b0;
            head_reg     <= 1'b0;
            count_reg    <= '0;
        end else begin
            wr_state_reg <= wr_state_next;
            wbank_reg    <= wbank_next;
            wcnt_reg     <= wcnt_next;
            full_reg     <= (full_reg | commit_mask) & ~rel_mask;
            pend_reg     <= (pend_reg | commit_mask) & ~start_mask;
            if (commit) begin
                len_reg[wbank_reg] <= wcnt_reg;
            end
            oldest_reg   <= oldest_next;
            ovf_drop_reg <= ovf_drop_reg | set_drop;
            ovf_len_reg  <= ovf_len_reg | set_len;
            rd_state_reg <= rd_state_next;
            rbank_reg    <= rbank_next;
            ridx_reg     <= ridx_next;
            rd_vld_reg   <= issue;
            head_reg     <= head_reg ^ pop;
            count_reg    <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    // Datapath registers only matter while qualified by rd_vld_reg/count_reg.
    always_ff @(posedge clk) begin
        if (issue) begin
            rd_bank_reg   <= cur_bank;
            rd_stream_reg <= cur_sec;
            rd_last_reg   <= sec_last && (cur_sec == STR_ZP);
        end
        if (push) begin
            fifo_data_reg[head_reg ^ count_reg[0]]   <= rdata[rd_bank_reg];
            fifo_stream_reg[head_reg ^ count_reg[0]] <= rd_stream_reg;
            fifo_last_reg[head_reg ^ count_reg[0]]   <= rd_last_reg;
            fifo_bank_reg[head_reg ^ count_reg[0]]   <= rd_bank_reg;
        end
    end

    assign ovf_drop = ovf_drop_reg;
    assign ovf_len  = ovf_len_reg;

endmodule

// File: tb/tb_enc_out_collector.sv
// Randomised bench for enc_out_collector: expected byte streams are built per
// block from the input beats and compared byte by byte at the output.
module tb_enc_out_collector;
    import coder_pkg::*;

    localparam int DEPTH = DEFAULT_DEPTH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ovf_drop, ovf_len;

    enc_out_collector_if bus_i ();

    enc_out_collector #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_i),
        .ovf_drop(ovf_drop),
        .ovf_len (ovf_len)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rx_count = 0;
    int first_valid_cyc = -1;
    int last_beat_cyc = 0;
    int bubble_target = 0;
    int ready_mode = 0;
    int blk_no = 0;
    bit mon_en = 1'b0;
    bit bubble_en = 1'b0;
    bit seen_zk = 1'b0;
    logic [10:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       bus_i.out_ready = 1'b0;
            1:       bus_i.out_ready = 1'b1;
            default: bus_i.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: ordering, stall stability and bubble detection.
    initial begin
        logic [10:0] got, e, prev_out;
        logic prev_stall;
        prev_stall = 1'b0;
        prev_out = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                got = {bus_i.out_last, bus_i.out_stream, bus_i.out_data};
                if (prev_stall) begin
                    chk("stall_valid", bus_i.out_valid, 1);
                    chk("stall_hold", got, prev_out);
                end
                if (bus_i.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (bus_i.out_valid && bus_i.out_stream == STR_ZK) seen_zk = 1'b1;
                if (bubble_en && first_valid_cyc >= 0 && rx_count < bubble_target)
                    chk("no_bubble", bus_i.out_valid, 1);
                if (bus_i.out_valid && bus_i.out_ready) begin
                    rx_count++;
                    chk("byte_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("byte", got, e);
                    end
                end
                prev_stall = bus_i.out_valid && !bus_i.out_ready;
                prev_out = got;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // mode 0: fixed 0x10/0x20/0x30 ramps, 1: index-derived, 2: random
    task automatic send_block(input int len, input int mode, input bit accepted);
        logic [7:0] xs [$];
        logic [7:0] zs [$];
        logic [7:0] ps [$];
        logic [7:0] x, z, p, b;
        int lc;
        for (int i = 0; i < len; i++) begin
            case (mode)
                0: begin x = 8'h10 + 8'(i); z = 8'h20 + 8'(i); p = 8'h30 + 8'(i); end
                1: begin x = 8'(i); z = 8'(i) ^ 8'h5a; p = 8'(i * 7 + 3); end
                default: begin x = 8'($urandom); z = 8'($urandom); p = 8'($urandom); end
            endcase
            @(posedge clk);
            #1;
            bus_i.in_valid = 1'b1;
            bus_i.xk_in = x;
            bus_i.zk_in = z;
            bus_i.zk_prime_in = p;
            last_beat_cyc = cyc;
            xs.push_back(x);
            zs.push_back(z);
            ps.push_back(p);
        end
        @(posedge clk);
        #1;
        bus_i.in_valid = 1'b0;
        lc = (len > DEPTH) ? DEPTH : len;
        if (accepted) begin
            for (int s = 0; s < 3; s++) begin
                for (int i = 0; i < lc; i++) begin
                    b = (s == 0) ? xs[i] : (s == 1) ? zs[i] : ps[i];
                    exp_q.push_back({(s == 2 && i == lc - 1), 2'(s), b});
                end
            end
        end
        blk_no++;
        $display("block %0d: %0d beats, %s", blk_no, len, accepted ? "stored" : "dropped");
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        for (int t = 0; t < max_cyc && exp_q.size() != 0; t++) @(posedge clk);
        chk(tag, exp_q.size(), 0);
        repeat (8) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    initial begin
        int ends [20];
        int total;
        bus_i.in_valid = 1'b0;
        bus_i.xk_in = '0;
        bus_i.zk_in = '0;
        bus_i.zk_prime_in = '0;
        bus_i.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus_i.out_valid, 0);
        chk("rst_out_last", bus_i.out_last, 0);
        chk("rst_out_stream", bus_i.out_stream, 0);
        chk("rst_out_data", bus_i.out_data, 0);
        chk("rst_ovf_drop", ovf_drop, 0);
        chk("rst_ovf_len", ovf_len, 0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Single 4-beat block and its latency
        ready_mode = 1;
        rx_count = 0;
        first_valid_cyc = -1;
        send_block(4, 0, 1);
        wait_drain("t1_drain", 50);
        chk("t1_latency", first_valid_cyc - last_beat_cyc, 3);
        chk("t1_count", rx_count, 12);

        // Back-to-back 768-beat blocks, no output bubbles
        rx_count = 0;
        first_valid_cyc = -1;
        bubble_target = 4608;
        bubble_en = 1'b1;
        send_block(768, 1, 1);
        send_block(768, 2, 1);
        wait_drain("t2_drain", 6000);
        bubble_en = 1'b0;
        chk("t2_count", rx_count, 4608);
        chk("t2_ovf_drop", ovf_drop, 0);
        chk("t2_ovf_len", ovf_len, 0);

        // Three blocks with the consumer stalled: third has no bank
        ready_mode = 0;
        rx_count = 0;
        send_block(8, 2, 1);
        send_block(8, 2, 1);
        send_block(8, 2, 0);
        repeat (4) @(posedge clk);
        chk("t3_ovf_drop", ovf_drop, 1);
        ready_mode = 1;
        wait_drain("t3_drain", 200);
        chk("t3_count", rx_count, 48);

        // Oversized block
        rx_count = 0;
        send_block(DEPTH + 5, 1, 1);
        #1;
        chk("t4_ovf_len", ovf_len, 1);
        wait_drain("t4_drain", 4000);
        chk("t4_count", rx_count, 3 * DEPTH);

        // Random lengths under random backpressure
        do_reset();
        #1;
        chk("t5_rst_ovf_drop", ovf_drop, 0);
        chk("t5_rst_ovf_len", ovf_len, 0);
        ready_mode = 2;
        rx_count = 0;
        total = 0;
        for (int k = 0; k < 20; k++) begin
            int len;
            len = $urandom_range(1, 40);
            total += 3 * len;
            ends[k] = total;
            if (k >= 2) begin
                for (int t = 0; t < 2000 && rx_count < ends[k-2]; t++) @(posedge clk);
                chk("t5_bank_wait", rx_count >= ends[k-2], 1);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send_block(len, 2, 1);
        end
        wait_drain("t5_drain", 4000);
        chk("t5_count", rx_count, total);
        chk("t5_ovf_drop", ovf_drop, 0);
        chk("t5_ovf_len", ovf_len, 0);

        // Raise ovf_drop again so the reset below has something to clear
        ready_mode = 0;
        send_block(2, 2, 1);
        send_block(2, 2, 1);
        send_block(2, 2, 0);
        repeat (3) @(posedge clk);
        chk("t6_pre_ovf_drop", ovf_drop, 1);
        ready_mode = 1;
        wait_drain("t6_pre_drain", 100);

        // Reset while the zk section is streaming
        seen_zk = 1'b0;
        send_block(6, 2, 1);
        for (int t = 0; t < 200 && !seen_zk; t++) @(negedge clk);
        chk("t6_reached_zk", seen_zk, 1);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t6_valid_after_rst", bus_i.out_valid, 0);
        chk("t6_ovf_drop", ovf_drop, 0);
        chk("t6_ovf_len", ovf_len, 0);
        exp_q.delete();
        rx_count = 0;
        mon_en = 1'b1;
        send_block(2, 2, 1);
        wait_drain("t6_drain", 100);
        chk("t6_count", rx_count, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
